// File: rtl/cntr8_ctrl_pkg.sv
// Shared types and constants for the cntr8 command-side controller.
package cntr8_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    JUMP   = 3'b001,
    SETTLE = 3'b010,
    RAMP   = 3'b011,
    DONE   = 3'b100
  } state_t;

  localparam logic MODE_JUMP = 1'b0;
  localparam logic MODE_RAMP = 1'b1;

endpackage

// File: rtl/cntr8_ctrl_ns.sv
// Next-state logic for cntr8_ctrl: chooses the request path and ends a ramp on target.
module cntr8_ctrl_ns
  import cntr8_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  state_t             state,
  input  logic               handshake,
  input  logic               req_mode,
  input  logic               mode_r,
  input  logic [WIDTH-1:0]   cnt_q,
  input  logic [WIDTH-1:0]   target_r,
  output state_t             next_state
);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (handshake) next_state = (req_mode == MODE_RAMP) ? RAMP : JUMP;
      end
      JUMP:   next_state = SETTLE;
      SETTLE: next_state = DONE;
      RAMP: begin
        // Compare against the live counter value so the last step lands exactly on target.
        if (mode_r != MODE_RAMP || cnt_q == target_r) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/cntr8_ctrl.sv
// Drives load/inc/d_in of the cntr8 counter to reach a requested target by jump or ramp.
module cntr8_ctrl
  import cntr8_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_mode,
  input  logic [WIDTH-1:0]   req_target,
  input  logic [WIDTH-1:0]   cnt_q,
  output logic               load,
  output logic               inc,
  output logic [WIDTH-1:0]   d_in,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] target_r;
  logic             mode_r;
  logic             handshake;
  logic             stepping;

  assign req_ready = (state == IDLE) && !reset;
  assign handshake = req_valid && req_ready;
  assign busy      = (state != IDLE);

  cntr8_ctrl_ns #(.WIDTH(WIDTH)) u_ns (
    .state      (state),
    .handshake  (handshake),
    .req_mode   (req_mode),
    .mode_r     (mode_r),
    .cnt_q      (cnt_q),
    .target_r   (target_r),
    .next_state (next_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      target_r <= '0;
      mode_r   <= MODE_JUMP;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (handshake) begin
        target_r <= req_target;
        mode_r   <= req_mode;
      end
      // done/err are registered so they coincide exactly with the DONE state.
      done <= (next_state == DONE);
      err  <= (state == SETTLE) && (cnt_q != target_r);
    end
  end

  assign stepping = (state == RAMP) && (cnt_q != target_r);

  // Reset forces HOLD in the same cycle so the counter freezes at once.
  always_comb begin
    load = 1'b1;
    inc  = 1'b0;
    d_in = cnt_q;
    if (!reset) begin
      if (state == JUMP) begin
        d_in = target_r;
      end else if (stepping) begin
        load = 1'b0;
        inc  = (target_r > cnt_q);
      end
    end
  end

endmodule
